// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the transmit arbiter.
// master = arbiter, slave = requesters plus the transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_byte;
    logic [NUM_REQ-1:0]   i_last;
    logic [NUM_REQ-1:0]   o_ack;
    logic [NUM_REQ-1:0]   o_grant;
    logic [2:0]           o_grant_id;
    logic                 o_tx_dv;
    logic [7:0]           o_tx_byte;
    logic                 i_tx_done;
    logic                 i_tx_active;
    logic                 o_busy;
    logic                 o_abort;

    modport master (
        input  i_req, i_byte, i_last, i_tx_done, i_tx_active,
        output o_ack, o_grant, o_grant_id, o_tx_dv, o_tx_byte,
        output o_busy, o_abort
    );

    modport slave (
        output i_req, i_byte, i_last, i_tx_done, i_tx_active,
        input  o_ack, o_grant, o_grant_id, o_tx_dv, o_tx_byte,
        input  o_busy, o_abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart_tx.
// An owner keeps the transmitter from first byte to last, or until it stalls.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [NUM_REQ-1:0] ack, ack_n;
    logic [2:0]         gid, gid_n;
    logic [2:0]         ptr, ptr_n;
    logic [7:0]         tx_byte, tx_byte_n;
    logic               r_last, last_n;
    logic               dv, dv_n;
    logic               abort, abort_n;
    logic [TW-1:0]      tmo, tmo_n, tmo_inc;

    logic [NUM_REQ-1:0] pick;
    logic [2:0]         pick_id;
    logic               found;
    int                 j;
    logic               own_req, own_last;
    logic [7:0]         own_byte;
    logic [2:0]         gid_inc;

    // First requester at or above the pointer, wrapping.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && k == j && bus.i_req[k]) begin
                    pick    = '0;
                    pick[k] = 1'b1;
                    pick_id = 3'(k);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                own_req  = bus.i_req[k];
                own_last = bus.i_last[k];
                own_byte = bus.i_byte[8*k +: 8];
            end
        end
    end

    assign gid_inc = (gid == 3'(NUM_REQ - 1)) ? 3'd0 : gid + 3'd1;
    assign tmo_inc = (tmo == TW'(TIMEOUT)) ? tmo : tmo + 1'b1;

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        gid_n     = gid;
        ptr_n     = ptr;
        tx_byte_n = tx_byte;
        last_n    = r_last;
        tmo_n     = tmo;
        ack_n     = '0;
        dv_n      = 1'b0;
        abort_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Never start while a byte from before a reset is still shifting out.
                if (found && !bus.i_tx_active) begin
                    grant_n = pick;
                    gid_n   = pick_id;
                    tmo_n   = '0;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (own_req) begin
                    tx_byte_n = own_byte;
                    last_n    = own_last;
                    ack_n     = grant;
                    dv_n      = 1'b1;
                    tmo_n     = '0;
                    state_n   = S_WAIT;
                end else if (tmo_inc == TW'(TIMEOUT)) begin
                    abort_n = 1'b1;
                    grant_n = '0;
                    ptr_n   = gid_inc;
                    tmo_n   = tmo_inc;
                    state_n = S_IDLE;
                end else begin
                    tmo_n = tmo_inc;
                end
            end
            S_WAIT: begin
                if (bus.i_tx_done) begin
                    if (r_last) begin
                        grant_n = '0;
                        ptr_n   = gid_inc;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_LOAD;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            grant   <= '0;
            gid     <= '0;
            ptr     <= '0;
            tx_byte <= 8'h00;
            r_last  <= 1'b0;
            tmo     <= '0;
            ack     <= '0;
            dv      <= 1'b0;
            abort   <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            gid     <= gid_n;
            ptr     <= ptr_n;
            tx_byte <= tx_byte_n;
            r_last  <= last_n;
            tmo     <= tmo_n;
            ack     <= ack_n;
            dv      <= dv_n;
            abort   <= abort_n;
        end
    end

    assign bus.o_ack      = ack;
    assign bus.o_grant    = grant;
    assign bus.o_grant_id = gid;
    assign bus.o_tx_dv    = dv;
    assign bus.o_tx_byte  = tx_byte;
    assign bus.o_busy     = (state != S_IDLE);
    assign bus.o_abort    = abort;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester and uart_tx models.
// Expected (owner, byte) pairs are queued in predicted service order.
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int TMO   = 20;
    localparam int TXLEN = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   dv_cnt = 0;
    int   dv_cyc = 0;
    int   abort_cnt = 0;
    int   abort_cyc = 0;
    int   ack_cnt [NR];
    logic m_done = 1'b0;
    logic m_act = 1'b0;
    logic s_done = 1'b0;
    logic s_act = 1'b0;
    logic [8:0]  rq_q [NR][$];
    logic [10:0] sb [$];

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_tx_done   = m_done | s_done;
    assign bus.i_tx_active = m_act | s_act;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rq(input int n, input logic [7:0] b, input logic l);
        rq_q[n].push_back({l, b});
    endtask

    task automatic ex(input int n, input logic [7:0] b);
        sb.push_back({3'(n), b});
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (k < 500 && !(sb.size() == 0 && !bus.o_busy && !bus.i_tx_active)) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 500), 32'd1);
    endtask

    task automatic wait_dv(input int target, input string tag);
        int k;
        k = 0;
        while (k < 200 && dv_cnt < target) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 200), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (k < 200 && !bus.i_tx_done) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 200), 32'd1);
    endtask

    task automatic wait_grant(input int n, input string tag);
        int k;
        k = 0;
        while (k < 200 && !bus.o_grant[n]) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 200), 32'd1);
    endtask

    // Requesters: present queue head, pop it when acked.
    initial begin
        logic [8:0] f;
        bus.i_req  = '0;
        bus.i_byte = '0;
        bus.i_last = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int n = 0; n < NR; n++) begin
                if (bus.o_ack[n] && rq_q[n].size() > 0) void'(rq_q[n].pop_front());
                f = (rq_q[n].size() > 0) ? rq_q[n][0] : 9'h000;
                bus.i_req[n]        = (rq_q[n].size() > 0);
                bus.i_byte[8*n +: 8] = f[7:0];
                bus.i_last[n]       = f[8];
            end
        end
    end

    // uart_tx: busy TXLEN cycles after each dv, then a one-cycle done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_tx_dv) begin
                m_act = 1'b1;
                repeat (TXLEN) @(posedge clk);
                #1;
                m_done = 1'b1;
                m_act  = 1'b0;
                @(posedge clk);
                #1;
                m_done = 1'b0;
            end
        end
    end

    initial begin
        logic [10:0] e;
        for (int n = 0; n < NR; n++) ack_cnt[n] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.o_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            for (int n = 0; n < NR; n++) if (bus.o_ack[n]) ack_cnt[n]++;
            chk("ack_dv_align", 32'(|bus.o_ack), 32'(bus.o_tx_dv));
            if (bus.o_tx_dv) begin
                dv_cnt++;
                dv_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("tx_byte", 32'(bus.o_tx_byte), 32'(e[7:0]));
                    chk("tx_owner", 32'(bus.o_grant_id), 32'(e[10:8]));
                    chk("ack_owner", 32'(bus.o_ack), 32'(4'b0001 << e[10:8]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a0;
        int  k;
        int  d0;
        logic g_seen;
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_ack", 32'(bus.o_ack), 32'd0);
        chk("rst_dv", 32'(bus.o_tx_dv), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_abort", 32'(bus.o_abort), 32'd0);
        chk("rst_byte", 32'(bus.o_tx_byte), 32'd0);
        chk("rst_gid", 32'(bus.o_grant_id), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // single requester, three-byte packet
        rq(0, 8'h41, 1'b0); ex(0, 8'h41);
        rq(0, 8'h42, 1'b0); ex(0, 8'h42);
        rq(0, 8'h43, 1'b1); ex(0, 8'h43);
        wait_dv(3, "t1_three_dv");
        wait_done("t1_third_done");
        chk("t1_grant_at_done", 32'(bus.o_grant), 32'd1);
        tick();
        chk("t1_grant_drop", 32'(bus.o_grant), 32'd0);
        chk("t1_ack_count", 32'(ack_cnt[0]), 32'd3);
        wait_idle("t1_idle");

        // req1 and req2 together, twice
        rq(1, 8'h10, 1'b1); ex(1, 8'h10);
        rq(2, 8'h20, 1'b1); ex(2, 8'h20);
        rq(1, 8'h11, 1'b1); ex(1, 8'h11);
        rq(2, 8'h21, 1'b1); ex(2, 8'h21);
        wait_idle("t2_idle");

        // req0 streaming two-byte packets, req3 pending
        rq(0, 8'hA0, 1'b0); ex(0, 8'hA0);
        rq(0, 8'hA1, 1'b1); ex(0, 8'hA1);
        rq(0, 8'hA2, 1'b0);
        rq(0, 8'hA3, 1'b1);
        wait_grant(0, "t3_grant0");
        rq(3, 8'hD0, 1'b1); ex(3, 8'hD0);
        ex(0, 8'hA2); ex(0, 8'hA3);
        rq(3, 8'hD1, 1'b1); ex(3, 8'hD1);
        wait_idle("t3_idle");
        chk("t3_ack3", 32'(ack_cnt[3]), 32'd2);

        // req2 stalls mid-packet, req0 waiting
        a0 = abort_cnt;
        rq(2, 8'h55, 1'b0); ex(2, 8'h55);
        wait_grant(2, "t4_grant2");
        rq(0, 8'h77, 1'b1); ex(0, 8'h77);
        k = 0;
        while (k < 200 && abort_cnt == a0) begin
            tick();
            k++;
        end
        chk("t4_abort_seen", 32'(k < 200), 32'd1);
        chk("t4_abort_grant", 32'(bus.o_grant), 32'd0);
        chk("t4_abort_time", 32'(abort_cyc - dv_cyc), 32'(TXLEN + 1 + TMO));
        wait_idle("t4_idle");
        chk("t4_abort_once", 32'(abort_cnt - a0), 32'd1);

        // asynchronous reset while a byte is in flight
        d0 = dv_cnt;
        rq(1, 8'hB1, 1'b0); ex(1, 8'hB1);
        rq(1, 8'hB2, 1'b1);
        wait_dv(d0 + 1, "t5_first_dv");
        tick();
        s_act = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("t5_grant", 32'(bus.o_grant), 32'd0);
        chk("t5_busy", 32'(bus.o_busy), 32'd0);
        chk("t5_byte", 32'(bus.o_tx_byte), 32'd0);
        chk("t5_gid", 32'(bus.o_grant_id), 32'd0);
        chk("t5_dv", 32'(bus.o_tx_dv), 32'd0);
        rq_q[1].delete();
        sb.delete();
        repeat (2) tick();
        reset = 1'b1;
        rq(0, 8'h99, 1'b1); ex(0, 8'h99);
        g_seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.o_grant != '0) g_seen = 1'b1;
        end
        chk("t5_no_grant_active", 32'(g_seen), 32'd0);
        @(posedge clk);
        #1;
        s_act = 1'b0;
        tick();
        chk("t5_grant_wait", 32'(bus.o_grant), 32'd0);
        tick();
        chk("t5_grant_now", 32'(bus.o_grant), 32'd1);
        chk("t5_dv_not_yet", 32'(bus.o_tx_dv), 32'd0);
        tick();
        chk("t5_dv_two_cycles", 32'(bus.o_tx_dv), 32'd1);
        wait_idle("t5_idle");

        // spurious done in IDLE
        d0 = dv_cnt;
        @(posedge clk);
        #1;
        s_done = 1'b1;
        @(posedge clk);
        #1;
        s_done = 1'b0;
        repeat (3) tick();
        chk("t6_idle_busy", 32'(bus.o_busy), 32'd0);
        chk("t6_idle_dv", 32'(dv_cnt - d0), 32'd0);

        // spurious done in LOAD
        a0 = abort_cnt;
        rq(3, 8'h11, 1'b0); ex(3, 8'h11);
        wait_dv(d0 + 1, "t6_first_dv");
        wait_done("t6_done");
        repeat (3) tick();
        chk("t6_load_grant", 32'(bus.o_grant), 32'h8);
        d0 = dv_cnt;
        @(posedge clk);
        #1;
        s_done = 1'b1;
        @(posedge clk);
        #1;
        s_done = 1'b0;
        repeat (2) tick();
        chk("t6_load_dv", 32'(dv_cnt - d0), 32'd0);
        chk("t6_load_busy", 32'(bus.o_busy), 32'd1);
        chk("t6_load_hold", 32'(bus.o_grant), 32'h8);
        rq(3, 8'h12, 1'b1); ex(3, 8'h12);
        wait_idle("t6_idle");
        chk("t6_no_abort", 32'(abort_cnt - a0), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_tx` transmitter between several byte-stream requesters, such as the echo path fed from the RX block memory and a button/status reporter. Each requester owns the transmitter for a whole packet, from its first byte through the byte flagged `last`. The arbiter drives the `uart_tx` `i_Tx_DV`/`i_Tx_Byte` handshake and paces bytes on `o_Tx_Done`. It also releases a stalled owner after a timeout.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 1023: cycles an owner may hold the grant with `i_req` low before it is forcibly released.
- `clk` in 1: system clock; every register updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `i_req` in NUM_REQ: per-requester flag meaning "a byte is presented"; level signal, held until acked.
- `i_byte` in 8*NUM_REQ: byte of requester n on bits [8n+7:8n].
- `i_last` in NUM_REQ: presented byte is the final byte of the packet.
- `o_ack` out NUM_REQ: one-hot, one-cycle pulse meaning "byte captured"; requester presents the next byte or drops `i_req` from the following cycle.
- `o_grant` out NUM_REQ: one-hot current owner; all zero when idle.
- `o_grant_id` out 3: index of the current owner; holds the last owner while idle.
- `o_tx_dv` out 1: to `uart_tx` `i_Tx_DV`; one-cycle pulse.
- `o_tx_byte` out 8: to `uart_tx` `i_Tx_Byte`; held stable until the next capture.
- `i_tx_done` in 1: from `uart_tx` `o_Tx_Done`.
- `i_tx_active` in 1: from `uart_tx` `o_Tx_Active`.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_abort` out 1: one-cycle pulse when a timeout release occurs.

## Operation
- Reset values: state IDLE; `o_ack`, `o_grant`, `o_tx_dv`, `o_busy`, `o_abort` all 0; `o_tx_byte` = 0x00; `o_grant_id` = 0; priority pointer = 0; timeout counter = 0.
- State IDLE:
  - If `i_req` != 0 and `i_tx_active` = 0, select the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Register `o_grant`/`o_grant_id`, go to LOAD.
  - Otherwise stay in IDLE.
- State LOAD:
  - If `i_req[owner]` = 1: capture `i_byte[owner]` into `o_tx_byte` and `i_last[owner]` into `r_last`, pulse `o_ack[owner]` and `o_tx_dv`, clear the timeout counter, go to WAIT.
  - If `i_req[owner]` = 0: increment the timeout counter.
  - When the counter reaches TIMEOUT: pulse `o_abort`, clear the grant, set pointer = owner+1 (mod NUM_REQ), go to IDLE.
- State WAIT:
  - On `i_tx_done` = 1 with `r_last` = 1: clear the grant, set pointer = owner+1 (mod NUM_REQ), go to IDLE.
  - On `i_tx_done` = 1 with `r_last` = 0: go to LOAD.
  - No timeout applies in WAIT.
- Only the owner's `i_req`, `i_byte` and `i_last` are observed; other requesters simply wait with `i_req` high.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and saturates at TIMEOUT.

## Timing
- Request sampled at edge k in IDLE gives `o_grant` valid after edge k.
- At edge k+1 (LOAD), `o_ack` and `o_tx_dv` assert together for exactly one cycle, with `o_tx_byte` valid at the same time.
- Minimum grant latency from `i_req` rising to `o_tx_dv` is 2 cycles.
- `i_tx_done` seen at edge d in WAIT:
  - Non-last byte: LOAD at d+1, next `o_tx_dv` at d+1, giving a 1-cycle inter-byte gap in arbiter terms.
  - Last byte: IDLE at d+1, new grant at d+2.
- `i_tx_done` while in IDLE or LOAD is ignored.
- A requester dropping `i_req` in the same cycle its ack pulses is legal, since the byte was already captured.
- Simultaneous release and new requests: arbitration occurs in the next IDLE cycle. The released owner has the lowest priority.
- Only the released owner is rotated past; starvation bound is NUM_REQ-1 packets.
- Reset asserted mid-packet: all outputs clear immediately, asynchronously. After release, no grant is issued until `i_tx_active` = 0, so a byte already in flight in `uart_tx` completes undisturbed.

## Test plan
- Single requester, 3-byte packet 0x41, 0x42, 0x43 on req0, last on 0x43:
  - Three `o_tx_dv` pulses carrying those bytes, each after the previous `i_tx_done`.
  - Grant drops 1 cycle after the third done; `o_ack[0]` pulses 3 times.
- req1 and req2 raised together after reset (pointer 0), one-byte packets each:
  - req1 is served first, then req2.
  - A repeat of both is served again as req1 then req2, confirming pointer rotation.
- req0 streaming 2-byte packets continuously while req3 is pending:
  - Order is req0, req3, req0, req3; req3 is never starved.
- req2 granted, sends byte 0x55 with `i_last`=0, then drops `i_req` for TIMEOUT cycles:
  - `o_abort` pulses once at TIMEOUT cycles; grant clears; pending req0 is granted next.
- Reset pulled low in WAIT with `i_tx_active` held high 20 more cycles:
  - All outputs go 0 immediately.
  - With `i_req`=0x1 after reset release, no grant until `i_tx_active` falls, then `o_tx_dv` 2 cycles later.
- Spurious `i_tx_done` injected in LOAD and in IDLE: no state change, no extra `o_tx_dv`.
